// File: rtl/fetch_trace_monitor.sv
// ============================================================================
// Module   : fetch_trace_monitor
// Purpose  : Passive monitor for the instruction-fetch request/valid port.
//            It records every accepted fetch into a circular trace buffer.
//            It counts accepted fetches, stall cycles and (optionally)
//            redirect mispredictions. It raises a sticky timeout when a
//            request stays unanswered for TIMEOUT consecutive cycles.
//            The trace is read back by index, where index 0 is the oldest
//            valid entry. Readout data is registered, so it appears one
//            cycle after rd_idx_i is applied.
// Options  : define TRACE_PRED_EN to store prediction fields per entry and
//            enable the mispredict counter. When it is undefined, those
//            outputs are tied to 0.
// Ports    : clk, rst (sync, active-high)
//            req_i, vld_i, pc_i, instr_i, pred_taken_i, pred_target_i
//                                        - observed fetch interface
//            enable_i                    - trace capture enable
//            clear_i                     - synchronous clear of trace,
//                                          counters and timeout
//            rd_idx_i -> rd_pc_o, rd_instr_o, rd_pred_taken_o,
//                        rd_pred_target_o
//                                        - registered trace readout
//            entries_o, wrapped_o        - trace occupancy status
//            fetch_cnt_o, stall_cnt_o, mispred_cnt_o
//                                        - saturating statistics counters
//            timeout_o, timeout_pc_o     - sticky timeout flag and the PC
//                                          captured when it fired
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_trace_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic                     vld_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [DATA_W-1:0]        instr_i,
  input  logic                     pred_taken_i,
  input  logic [ADDR_W-1:0]        pred_target_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]        rd_pc_o,
  output logic [DATA_W-1:0]        rd_instr_o,
  output logic                     rd_pred_taken_o,
  output logic [ADDR_W-1:0]        rd_pred_target_o,
  output logic [$clog2(DEPTH):0]   entries_o,
  output logic                     wrapped_o,
  output logic [CNT_W-1:0]         fetch_cnt_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         mispred_cnt_o,
  output logic                     timeout_o,
  output logic [ADDR_W-1:0]        timeout_pc_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]      ENT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ENT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WCW-1:0]   WCNT_ONE = WCW'(1);
  localparam logic [WCW-1:0]   WCNT_TO  = WCW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_t;

  // clear_i behaves exactly like reset and overrides a same-cycle accept.
  logic clr;
  logic accept;
  logic stall;
  logic capture;

  assign clr     = rst | clear_i;
  assign accept  = req_i & vld_i;
  assign stall   = req_i & ~vld_i;
  assign capture = accept & enable_i & ~clr;

  // --------------------------------------------------------------------------
  // Timeout FSM
  // --------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic             tout_set;
  logic [ADDR_W-1:0] timeout_pc;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      timeout_pc <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (tout_set) timeout_pc <= pc_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    tout_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (stall) begin
          // A single-cycle budget means the very first stall times out.
          if (TIMEOUT == 1) begin
            state_nxt = S_TOUT;
            tout_set  = 1'b1;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WCNT_ONE;
          end
        end
      end
      S_WAIT: begin
        if (!stall) begin
          // Either answered or withdrawn; both end the wait without timeout.
          state_nxt    = S_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt + WCNT_ONE == WCNT_TO) begin
          state_nxt    = S_TOUT;
          wait_cnt_nxt = '0;
          tout_set     = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCNT_ONE;
        end
      end
      S_TOUT: begin
        state_nxt = S_TOUT;
      end
      default: begin
        state_nxt    = S_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign timeout_o    = (state == S_TOUT);
  assign timeout_pc_o = timeout_pc;

  // --------------------------------------------------------------------------
  // Statistics counters (saturating)
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && fetch_cnt != CNT_MAX) fetch_cnt <= fetch_cnt + CNT_ONE;
      if (stall && stall_cnt != CNT_MAX)  stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign stall_cnt_o = stall_cnt;

  // --------------------------------------------------------------------------
  // Trace buffer pointers and occupancy
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   entries;
  logic          wrapped;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      entries <= '0;
      wrapped <= 1'b0;
    end else if (capture) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (entries == ENT_FULL) wrapped <= 1'b1;
      else                     entries <= entries + ENT_ONE;
    end
  end

  assign entries_o = entries;
  assign wrapped_o = wrapped;

  // Once wrapped, the oldest entry sits at the write pointer.
  logic [AW-1:0] rd_slot;
  logic          rd_hit;

  assign rd_slot = (wrapped ? wr_ptr : '0) + rd_idx_i;
  assign rd_hit  = ({1'b0, rd_idx_i} < entries);

  // Storage is not reset: occupancy gates every read, so stale contents are
  // never visible.
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
    end
  end

  // Non-blocking read of the pre-edge array returns old data on a
  // same-cycle write to the selected slot.
  always_ff @(posedge clk) begin
    if (clr || !rd_hit) begin
      rd_pc    <= '0;
      rd_instr <= '0;
    end else begin
      rd_pc    <= pc_mem[rd_slot];
      rd_instr <= instr_mem[rd_slot];
    end
  end

  assign rd_pc_o    = rd_pc;
  assign rd_instr_o = rd_instr;

  // --------------------------------------------------------------------------
  // Prediction storage and mispredict tracking
  // --------------------------------------------------------------------------
`ifdef TRACE_PRED_EN
  logic              pt_mem  [DEPTH];
  logic [ADDR_W-1:0] ptg_mem [DEPTH];
  logic              rd_pt;
  logic [ADDR_W-1:0] rd_ptg;
  logic              last_taken;
  logic [ADDR_W-1:0] last_target;
  logic [CNT_W-1:0]  mispred_cnt;

  always_ff @(posedge clk) begin
    if (capture) begin
      pt_mem[wr_ptr]  <= pred_taken_i;
      ptg_mem[wr_ptr] <= pred_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || !rd_hit) begin
      rd_pt  <= 1'b0;
      rd_ptg <= '0;
    end else begin
      rd_pt  <= pt_mem[rd_slot];
      rd_ptg <= ptg_mem[rd_slot];
    end
  end

  // The previous accepted fetch predicted taken; the next fetched PC must
  // match its target, otherwise the front end was redirected.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_taken  <= 1'b0;
      last_target <= '0;
      mispred_cnt <= '0;
    end else if (accept) begin
      last_taken  <= pred_taken_i;
      last_target <= pred_target_i;
      if (last_taken && pc_i != last_target && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

  assign rd_pred_taken_o  = rd_pt;
  assign rd_pred_target_o = rd_ptg;
  assign mispred_cnt_o    = mispred_cnt;
`else
  logic unused_pred;
  assign unused_pred = ^{pred_taken_i, pred_target_i};

  assign rd_pred_taken_o  = 1'b0;
  assign rd_pred_target_o = '0;
  assign mispred_cnt_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_trace_monitor.sv
// ============================================================================
// Module   : tb_fetch_trace_monitor
// Purpose  : Scoreboard bench for fetch_trace_monitor (DEPTH=16, TIMEOUT=4).
//            The stimulus process queues the values it expects for the
//            current cycle. A separate monitor pops and compares them on the
//            falling edge of that cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_trace_monitor;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int TOUT   = 4;
    localparam int CNT_W  = 32;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              req, vld, pred_taken, enable, clear;
    logic [ADDR_W-1:0] pc, pred_target;
    logic [DATA_W-1:0] instr;
    logic [AW-1:0]     rd_idx;
    logic [ADDR_W-1:0] rd_pc, rd_pred_target, timeout_pc;
    logic [DATA_W-1:0] rd_instr;
    logic              rd_pred_taken, wrapped, timeout;
    logic [AW:0]       entries;
    logic [CNT_W-1:0]  fetch_cnt, stall_cnt, mispred_cnt;

    fetch_trace_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .vld_i(vld), .pc_i(pc), .instr_i(instr),
        .pred_taken_i(pred_taken), .pred_target_i(pred_target),
        .enable_i(enable), .clear_i(clear), .rd_idx_i(rd_idx),
        .rd_pc_o(rd_pc), .rd_instr_o(rd_instr),
        .rd_pred_taken_o(rd_pred_taken), .rd_pred_target_o(rd_pred_target),
        .entries_o(entries), .wrapped_o(wrapped),
        .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt), .mispred_cnt_o(mispred_cnt),
        .timeout_o(timeout), .timeout_pc_o(timeout_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            0:  return 64'(rd_pc);
            1:  return 64'(rd_instr);
            2:  return 64'(entries);
            3:  return 64'(wrapped);
            4:  return 64'(fetch_cnt);
            5:  return 64'(stall_cnt);
            6:  return 64'(mispred_cnt);
            7:  return 64'(timeout);
            8:  return 64'(timeout_pc);
            9:  return 64'(rd_pred_taken);
            10: return 64'(rd_pred_target);
            default: return 64'hDEAD;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic [63:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            vectors++;
            if (e.at != cyc || a !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, a, e.exp, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int sel, input logic [63:0] v);
        q.push_back('{cyc, nm, sel, v});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic accept(input logic [31:0] p, input logic [31:0] ins,
                          input logic pt, input logic [31:0] ptg);
        req = 1'b1; vld = 1'b1; pc = p; instr = ins; pred_taken = pt; pred_target = ptg;
        tick();
        req = 1'b0; vld = 1'b0; pred_taken = 1'b0; pred_target = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 0; vld = 0; pc = '0; instr = '0; pred_taken = 0;
        pred_target = '0; enable = 1'b1; clear = 0; rd_idx = '0;
        tick(); tick();
        expect_val("rst_entries", 2, 0);
        expect_val("rst_wrapped", 3, 0);
        expect_val("rst_fetch",   4, 0);
        expect_val("rst_stall",   5, 0);
        expect_val("rst_mispred", 6, 0);
        expect_val("rst_timeout", 7, 0);
        expect_val("rst_rd_pc",   0, 0);
        vectors++;
        if (entries !== '0) begin
            miscompares++;
            $display("FAIL rst_entries_direct: got 0x%0h expected 0x0", entries);
        end
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_timeout_direct: got 0x%0h expected 0x0", timeout);
        end
        rst = 1'b0;
        tick();

        for (int n = 0; n < 5; n++) accept(32'(4*n), 32'(32'hA0 + n), 1'b0, '0);
        expect_val("t1_entries", 2, 5);
        expect_val("t1_fetch",   4, 5);
        expect_val("t1_wrapped", 3, 0);
        rd_idx = AW'(2);
        tick();
        expect_val("t1_rd_pc",    0, 64'h8);
        expect_val("t1_rd_instr", 1, 64'hA2);
        rd_idx = AW'(5);
        tick();
        expect_val("t1_rd_oob", 0, 0);

        do_clear();
        for (int n = 0; n < 20; n++) begin
            accept(32'(4*n), 32'(n), 1'b0, '0);
            if (n == 15) begin
                expect_val("t2_full_entries", 2, 16);
                expect_val("t2_full_nowrap",  3, 0);
            end
        end
        expect_val("t2_entries", 2, 16);
        expect_val("t2_wrapped", 3, 1);
        expect_val("t2_fetch",   4, 20);
        rd_idx = AW'(0);
        tick();
        expect_val("t2_rd_oldest", 0, 64'h10);
        rd_idx = AW'(15);
        tick();
        expect_val("t2_rd_newest", 0, 64'h4C);

        do_clear();
        req = 1'b1; vld = 1'b0; pc = 32'h100;
        for (int n = 0; n < 3; n++) tick();
        expect_val("t3_no_tout_yet", 7, 0);
        tick();
        expect_val("t3_timeout",    7, 1);
        expect_val("t3_timeout_pc", 8, 64'h100);
        expect_val("t3_stall",      5, 4);
        vld = 1'b1;
        tick();
        expect_val("t3_sticky", 7, 1);
        expect_val("t3_fetch",  4, 1);
        req = 1'b0; vld = 1'b0;
        do_clear();
        expect_val("t3_clr_timeout", 7, 0);
        expect_val("t3_clr_tpc",     8, 0);
        expect_val("t3_clr_stall",   5, 0);
        expect_val("t3_clr_fetch",   4, 0);
        expect_val("t3_clr_entries", 2, 0);

        req = 1'b1; vld = 1'b0; pc = 32'h200;
        for (int n = 0; n < 3; n++) tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        req = 1'b0;
        expect_val("t4_no_timeout", 7, 0);
        expect_val("t4_stall",      5, 6);
        do_clear();

        accept(32'h20, 32'h1, 1'b1, 32'h80);
        accept(32'h24, 32'h2, 1'b0, '0);
`ifdef TRACE_PRED_EN
        expect_val("t5_mispred", 6, 1);
`else
        expect_val("t5_mispred", 6, 0);
`endif
        accept(32'h28, 32'h3, 1'b1, 32'h30);
        accept(32'h30, 32'h4, 1'b0, '0);
`ifdef TRACE_PRED_EN
        expect_val("t5_mispred_hold", 6, 1);
`else
        expect_val("t5_mispred_hold", 6, 0);
`endif
        rd_idx = AW'(0);
        tick();
        expect_val("t5_rd_pc", 0, 64'h20);
`ifdef TRACE_PRED_EN
        expect_val("t5_rd_ptaken", 9,  1);
        expect_val("t5_rd_ptgt",   10, 64'h80);
`else
        expect_val("t5_rd_ptaken", 9,  0);
        expect_val("t5_rd_ptgt",   10, 0);
`endif

        do_clear();
        accept(32'h40, 32'h5, 1'b0, '0);
        accept(32'h44, 32'h6, 1'b0, '0);
        expect_val("t6_pre_entries", 2, 2);
        clear = 1'b1;
        accept(32'h48, 32'h7, 1'b0, '0);
        clear = 1'b0;
        expect_val("t6_clr_entries", 2, 0);
        expect_val("t6_clr_fetch",   4, 0);
        enable = 1'b0;
        accept(32'h4C, 32'h8, 1'b0, '0);
        enable = 1'b1;
        expect_val("t6_dis_fetch",   4, 1);
        expect_val("t6_dis_entries", 2, 0);
        vectors++;
        if (fetch_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL t6_dis_fetch_direct: got 0x%0h expected 0x1", fetch_cnt);
        end
        vectors++;
        if (entries !== '0) begin
            miscompares++;
            $display("FAIL t6_dis_entries_direct: got 0x%0h expected 0x0", entries);
        end

        tick(); tick(); tick();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no check expected 0x%0h", e.name, e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_trace_monitor.md
Name: fetch_trace_monitor

Overview:
Synthesizable fetch-interface monitor. It sits beside the core's instruction-memory request/valid port and watches it passively. It records every accepted fetch (PC, instruction, optional prediction info) into a parametrised circular trace buffer, and counts fetches and stall cycles. It also flags a sticky fetch timeout when a request goes unanswered for too long. Software or the bench reads the trace back by index; the block never drives the fetch interface.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, instruction width
DEPTH, 16, trace entries; power of 2, at least 2
TIMEOUT, 64, consecutive unanswered request cycles that trigger timeout; at least 1
CNT_W, 32, width of all statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_i  in  1  core fetch request
vld_i  in  1  memory response valid
pc_i  in  ADDR_W  fetch PC
instr_i  in  DATA_W  returned instruction
pred_taken_i  in  1  predictor taken flag for this fetch
pred_target_i  in  ADDR_W  predicted target
enable_i  in  1  capture enable
clear_i  in  1  synchronous clear of trace, counters and timeout
rd_idx_i  in  log2(DEPTH)  readout index; 0 = oldest valid entry
rd_pc_o  out  ADDR_W  PC of selected entry
rd_instr_o  out  DATA_W  instruction of selected entry
rd_pred_taken_o  out  1  stored predictor taken flag
rd_pred_target_o  out  ADDR_W  stored predicted target
entries_o  out  log2(DEPTH)+1  valid entry count
wrapped_o  out  1  buffer has overwritten at least once
fetch_cnt_o  out  CNT_W  accepted fetches
stall_cnt_o  out  CNT_W  cycles with req_i=1, vld_i=0
mispred_cnt_o  out  CNT_W  redirect mismatches
timeout_o  out  1  sticky timeout flag
timeout_pc_o  out  ADDR_W  pc_i at timeout

Behaviour:
- Accept: req_i && vld_i at a rising edge. Stall: req_i && !vld_i.
- Reset values: all outputs 0; write pointer 0; FSM in IDLE.
- clear_i has the same effect as rst. When asserted, it has priority over a same-cycle accept; that fetch is dropped and not counted.
- FSM states:
  - IDLE: on stall, wait counter = 1 and go to WAIT.
  - WAIT: on accept, go to IDLE and zero the wait counter. On req_i=0, go to IDLE (request withdrawn, no timeout). On stall, increment the wait counter. When it would reach TIMEOUT, go to TOUT, set timeout_o=1 and latch timeout_pc_o=pc_i.
  - TOUT: sticky; leave only via rst or clear_i. Capture and counters keep running.
- With TIMEOUT=1, the first stall cycle times out.
- Capture (accept && enable_i):
  - Write {pc, instr, pred_taken, pred_target} at the write pointer, then increment the pointer modulo DEPTH.
  - entries_o saturates at DEPTH.
  - wrapped_o sets on the first write while entries_o == DEPTH.
- With enable_i=0, nothing is written to the trace, but all counters still update.
- Counters: fetch_cnt_o increments on accept; stall_cnt_o increments on each stall cycle. Both saturate at all-ones and never wrap.
- Mispredict tracking:
  - The block remembers pred_taken and pred_target of the last accepted fetch.
  - On the next accept, if the remembered pred_taken=1 and pc_i differs from the remembered pred_target, mispred_cnt_o increments.
  - The remembered state is cleared by rst and clear_i.
- Readout:
  - Physical slot = (wrapped_o ? write pointer : 0) + rd_idx_i, modulo DEPTH.
  - Outputs are registered, so data appears 1 cycle after rd_idx_i.
  - rd_idx_i >= entries_o returns all zeros.
  - A same-cycle write to the selected slot returns the old data.
- Outputs entries_o, wrapped_o, counters and timeout_o reflect an accept on the cycle after the edge.

Optional Feature:
TRACE_PRED_EN
- Defined: prediction fields are stored per entry, rd_pred_* return them, and mispred_cnt_o is active.
- Undefined: prediction storage and mispredict logic are removed; rd_pred_taken_o, rd_pred_target_o and mispred_cnt_o are tied to 0; pred_* inputs are ignored.

Test Plan:
- Reset, then 5 accepts with PC 0x0,0x4,0x8,0xC,0x10 and instr 0xA0..0xA4. Expect entries_o=5, fetch_cnt_o=5, wrapped_o=0, and rd_idx_i=2 giving rd_pc_o=0x8, rd_instr_o=0xA2 one cycle later.
- DEPTH=16, 20 accepts with PC=4*n. Expect entries_o=16, wrapped_o=1, rd_idx_i=0 giving PC 0x10, rd_idx_i=15 giving PC 0x4C.
- TIMEOUT=4, req_i=1, vld_i=0 held with pc_i=0x100. Expect timeout_o=1 after the 4th stall cycle, timeout_pc_o=0x100, stall_cnt_o=4. Then vld_i=1: timeout_o stays 1; clear_i zeroes everything.
- 3 stall cycles, req_i drops, 3 more stall cycles with TIMEOUT=4. Expect no timeout and stall_cnt_o=6.
- TRACE_PRED_EN: accept PC 0x20 with pred_taken=1, pred_target=0x80, then accept PC 0x24. Expect mispred_cnt_o=1. Then accept with pred_target=0x30, then PC 0x30: no increment.
- clear_i and an accept in the same cycle, and an accept during enable_i=0. Expect the cleared cycle to give entries_o=0, fetch_cnt_o=0. The enable_i=0 accept increments fetch_cnt_o but leaves entries_o unchanged.
